// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its output buffer.
package keypad_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int KEY_W      = $clog2(NUM_ROWS * NUM_COLS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } scan_state_e;

    // Index of the lowest-numbered zero bit; 0 when no bit is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Key output buffer: DEPTH-entry FIFO with valid/ready drain and sticky overflow.
module keypad_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [KEY_W-1:0] push_data_i,
    output logic [KEY_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             pop;
    logic             full;
    logic             accept;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign overflow_o  = overflow_q;
    assign pop         = out_valid_o && out_ready_i;
    assign full        = (count_q == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign accept      = push_i && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push_i && !accept) overflow_q <= 1'b1;
            if (accept && !pop)      count_q <= count_q + 1'b1;
            else if (!accept && pop) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and buffered key output.
// Define KEYPAD_FIFO_EN for a 4-deep key FIFO; otherwise a single holding register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [3:0]       row,
    input  logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             overflow
);

`ifdef KEYPAD_FIFO_EN
    localparam int BUF_DEPTH = FIFO_DEPTH;
`else
    localparam int BUF_DEPTH = 1;
`endif

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    scan_state_e      state_q;
    logic [3:0]       col_meta_q;
    logic [3:0]       col_sync_q;
    logic [3:0]       row_q;
    logic [3:0]       pattern_q;
    logic [KEY_W-1:0] code_q;
    logic [DIV_W-1:0] dwell_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             sample;
    logic             all_high;
    logic             deb_done;

    assign row      = row_q;
    assign sample   = (dwell_q == DIV_W'(SCAN_DIV - 1));
    assign all_high = &col_sync_q;
    assign deb_done = (deb_cnt_q == DEB_W'(DEBOUNCE_CNT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCAN;
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
            row_q      <= 4'b1110;
            pattern_q  <= 4'b1111;
            code_q     <= '0;
            dwell_q    <= '0;
            deb_cnt_q  <= '0;
        end else begin
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
            dwell_q    <= sample ? '0 : dwell_q + 1'b1;
            unique case (state_q)
                SCAN: begin
                    if (sample) begin
                        if (all_high) begin
                            row_q <= {row_q[2:0], row_q[3]};
                        end else begin
                            pattern_q <= col_sync_q;
                            code_q    <= {lowest_low(row_q), lowest_low(col_sync_q)};
                            deb_cnt_q <= '0;
                            state_q   <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (sample) begin
                        if (col_sync_q == pattern_q) begin
                            if (deb_done) begin
                                deb_cnt_q <= '0;
                                state_q   <= EMIT;
                            end else begin
                                deb_cnt_q <= deb_cnt_q + 1'b1;
                            end
                        end else begin
                            deb_cnt_q <= '0;
                            row_q     <= {row_q[2:0], row_q[3]};
                            state_q   <= SCAN;
                        end
                    end
                end
                EMIT: begin
                    deb_cnt_q <= '0;
                    state_q   <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // Any low sample restarts the release count.
                    if (sample) begin
                        if (!all_high) begin
                            deb_cnt_q <= '0;
                        end else if (deb_done) begin
                            deb_cnt_q <= '0;
                            row_q     <= {row_q[2:0], row_q[3]};
                            state_q   <= SCAN;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    keypad_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (state_q == EMIT),
        .push_data_i (code_q),
        .out_data_o  (key_code),
        .out_valid_o (key_valid),
        .out_ready_i (key_ready),
        .overflow_o  (overflow)
    );

endmodule
